// File: rtl/spi_pkg.sv
// Shared SPI definitions for the peripheral and controller.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_TX_IDLE = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with registered edge pulses.
// q, rise and fall change on the same clk edge, so rise/fall describe q.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  // Synchronizer chain plus edge detection on the last two stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      rise   <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall   <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : spi_sync_edge

// File: rtl/spi_peripheral_sync.sv
// SPI mode-0 peripheral running entirely in the clk domain.
// SCK/CS_N/MOSI are oversampled; local logic sees byte-wide valid/ready ports.
module spi_peripheral_sync
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = SPI_DATA_W,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(SPI_TX_IDLE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] tx_hold_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] tx_shift_d;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] rx_shift_q;
  logic              word_done_q;

  logic load_word, shift_bit, sample_bit, drop_xfer;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sck),
    .q     (sck_s),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI synchronizer, same depth as SCK so data lines up with the synced rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; a cs_n rise masks any sck edge.
  always_comb begin
    state_d    = state_q;
    load_word  = 1'b0;
    shift_bit  = 1'b0;
    sample_bit = 1'b0;
    drop_xfer  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          load_word = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          drop_xfer = 1'b1;
        end else if (sck_rise) begin
          sample_bit = 1'b1;
        end else if (sck_fall) begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            load_word = 1'b1;
          end else begin
            shift_bit = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word to send next: queued data, or the idle pattern on underrun.
  assign word_next = tx_ready ? TX_IDLE : tx_hold_q;

  // Next TX shift contents; miso always reflects its MSB while active.
  always_comb begin
    tx_shift_d = tx_shift_q;
    if (load_word) begin
      tx_shift_d = word_next;
    end else if (shift_bit) begin
      tx_shift_d = tx_shift_q << 1;
    end
  end

  // TX holding register, shift register, bit counter and miso drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_hold_q  <= '0;
      tx_ready   <= 1'b1;
      tx_shift_q <= '0;
      cnt_q      <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= ~cs_s;
      underrun   <= load_word & tx_ready;
      tx_shift_q <= tx_shift_d;
      if (tx_valid && tx_ready) begin
        tx_hold_q <= tx_data;
        tx_ready  <= 1'b0;
      end else if (load_word) begin
        tx_ready  <= 1'b1;
      end
      if (load_word || shift_bit) begin
        miso <= tx_shift_d[DATA_W-1];
      end
      if (load_word) begin
        cnt_q   <= '0;
        miso_oe <= 1'b1;
      end else if (sample_bit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (drop_xfer) begin
        cnt_q   <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end
    end
  end

  // RX shift register and output handshake; a new word always overwrites.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift_q  <= '0;
      word_done_q <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      word_done_q <= sample_bit && (cnt_q == CNT_W'(DATA_W - 1));
      overrun     <= 1'b0;
      if (sample_bit) begin
        rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
      end
      if (word_done_q) begin
        rx_data  <= rx_shift_q;
        rx_valid <= 1'b1;
        overrun  <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule : spi_peripheral_sync

// File: tb/tb_spi_peripheral_sync.sv
// Bench for spi_peripheral_sync: SPI controller model, rx scoreboard, random transfers.
module tb_spi_peripheral_sync;

  localparam int HALF = 5;  // clk periods per SCK phase

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       busy;
  logic       overrun;
  logic       underrun;

  spi_peripheral_sync dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .overrun  (overrun),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [7:0] exp_rx[$];    // words the peripheral must still hand to local logic
  logic [7:0] tx_pend[$];   // words queued by local logic, not yet sent
  int exp_under = 0;
  int exp_over  = 0;
  int got_under = 0;
  int got_over  = 0;

  // Controller transfer description.
  logic [7:0] c_words[4];
  logic [7:0] c_txw[4];
  bit         c_qtx[4];
  int         c_nw;
  int         c_lastbits;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each word start takes the queued word, or the idle pattern with an underrun.
  function automatic logic [7:0] model_word_start();
    if (tx_pend.size() > 0) return tx_pend.pop_front();
    exp_under++;
    return 8'hFF;
  endfunction

  // A completed word replaces any word local logic has not yet taken.
  function automatic void model_word_done(input logic [7:0] w);
    if (!rx_ready && exp_rx.size() > 0) begin
      void'(exp_rx.pop_back());
      exp_over++;
    end
    exp_rx.push_back(w);
  endfunction

  // Scoreboard monitor: samples after the drive point, before the next active edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (underrun) got_under++;
      if (overrun)  got_over++;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected got=%0h exp=none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
      end
    end
  end

  task automatic push_tx(input logic [7:0] d);
    int t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      n_checks++;
      $display("FAIL tx_ready_timeout got=0 exp=1");
    end else begin
      @(negedge clk);
      tx_pend.push_back(d);
    end
    tx_valid = 1'b0;
  endtask

  // One cs_n-framed transfer; the final SCK fall coincides with cs_n rise.
  task automatic xfer();
    logic [7:0] cw;
    logic [7:0] exp_m;
    logic [7:0] got;
    int nb;
    bit last;
    if (c_qtx[0]) push_tx(c_txw[0]);
    cw   = c_words[0];
    cs_n = 1'b0;
    mosi = cw[7];
    for (int w = 0; w < c_nw; w++) begin
      cw    = c_words[w];
      nb    = (w == c_nw - 1) ? c_lastbits : 8;
      exp_m = model_word_start();
      wait_clk(4);
      if (w + 1 < c_nw && c_qtx[w+1]) push_tx(c_txw[w+1]);
      wait_clk(HALF);
      got = '0;
      for (int b = 0; b < nb; b++) begin
        sck = 1'b1;
        got = {got[6:0], miso};
        if (b == 7) model_word_done(cw);
        wait_clk(HALF);
        last = (w == c_nw - 1) && (b == nb - 1);
        if (last) begin
          cs_n = 1'b1;
          sck  = 1'b0;
        end else begin
          sck = 1'b0;
          if (b < 7) begin
            int idx = 6 - b;
            mosi = cw[idx];
          end else begin
            logic [7:0] nw = c_words[w+1];
            mosi = nw[7];
          end
          if (b < nb - 1) wait_clk(HALF);
        end
      end
      check("miso_word", 32'(got), 32'(exp_m >> (8 - nb)));
    end
    wait_clk(10);
    check("idle_miso_oe", 32'(miso_oe), 32'd0);
    check("idle_miso", 32'(miso), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_underruns"}, 32'(got_under), 32'(exp_under));
    check({tag, "_overruns"}, 32'(got_over), 32'(exp_over));
  endtask

  task automatic one_word(input logic [7:0] m, input bit q, input logic [7:0] t, input int nb);
    c_nw = 1; c_words[0] = m; c_qtx[0] = q; c_txw[0] = t; c_lastbits = nb;
    xfer();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    wait_clk(4);
    check_reset_vals();
    rst_n = 1'b1;
    wait_clk(4);

    // Queued 3C answered while A5 is received.
    one_word(8'hA5, 1'b1, 8'h3C, 8);
    check_counts("basic");

    // Nothing queued: idle pattern and a single underrun.
    one_word(8'h00, 1'b0, 8'h00, 8);
    check_counts("underrun");

    // Two back-to-back words under one chip select.
    c_nw = 2; c_lastbits = 8;
    c_words[0] = 8'h12; c_words[1] = 8'h34;
    c_qtx[0] = 1'b1; c_txw[0] = 8'hAB; c_qtx[1] = 1'b1; c_txw[1] = 8'hCD;
    xfer();
    check_counts("b2b");

    // Local logic stalls across two words: second overwrites first.
    rx_ready = 1'b0;
    c_nw = 2; c_lastbits = 8;
    c_words[0] = 8'h6E; c_words[1] = 8'h91;
    c_qtx[0] = 1'b0; c_qtx[1] = 1'b0;
    xfer();
    check("ovr_rx_valid", 32'(rx_valid), 32'd1);
    check("ovr_rx_data", 32'(rx_data), 32'h91);
    rx_ready = 1'b1;
    wait_clk(4);
    check_counts("overrun");

    // Aborted half word yields nothing; the following word is clean.
    one_word(8'hF0, 1'b1, 8'h81, 4);
    wait_clk(4);
    check("partial_no_rx", 32'(rx_valid), 32'd0);
    one_word(8'h55, 1'b1, 8'h42, 8);
    check_counts("partial");

    // Reset during bit 3 with a word waiting in the holding register.
    push_tx(8'h77);
    cs_n = 1'b0; mosi = 1'b1;
    void'(model_word_start());
    wait_clk(4);
    push_tx(8'h99);
    wait_clk(HALF);
    for (int b = 0; b < 3; b++) begin
      sck = 1'b1; wait_clk(HALF);
      sck = 1'b0; wait_clk(HALF);
    end
    sck = 1'b1; wait_clk(2);
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0;
    tx_pend.delete();
    wait_clk(1);
    check_reset_vals();
    rst_n = 1'b1;
    wait_clk(6);
    one_word(8'h5A, 1'b0, 8'h00, 8);
    check_counts("reset");

    // Randomized transfers against the model.
    for (int i = 0; i < 20; i++) begin
      c_nw = $urandom_range(1, 3);
      c_lastbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
      for (int w = 0; w < 4; w++) begin
        c_words[w] = 8'($urandom);
        c_txw[w]   = 8'($urandom);
        c_qtx[w]   = bit'($urandom_range(0, 1));
      end
      rx_ready = ($urandom_range(0, 5) != 0);
      xfer();
      rx_ready = 1'b1;
      wait_clk(4);
    end
    check_counts("random");
    check("rx_left_over", 32'(exp_rx.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_peripheral_sync
